// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption engine.
// Expands the round keys one per clock after the inputs are latched, then
// runs the inverse cipher one sub-step (InvShiftRows, InvSubBytes,
// AddRoundKey, InvMixColumns) per clock. The state is column-major:
// byte k occupies bits [127-8k : 120-8k].
module aes_decrypt_core (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         AES_START,
    input  logic [127:0] AES_KEY,
    input  logic [127:0] AES_MSG_ENC,
    output logic [127:0] AES_MSG_DEC,
    output logic         AES_DONE,
    output logic         AES_BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        INIT,
        INV_SHIFT,
        INV_SUB,
        ADD_KEY,
        INV_MIX,
        DONE
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [127:0] aes_state;
    logic [127:0] rk [0:10];
    logic [3:0]   round_cnt;
    logic         run_ok;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic, polynomial x^8 + x^4 + x^3 + x + 1
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Forward S-box: inverse followed by the affine transform (constant 0x63).
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        logic [7:0] r;
        logic [7:0] c;
        c = 8'h63;
        v = gf_inv(x);
        for (int i = 0; i < 8; i++) begin
            r[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8]
                 ^ v[(i + 7) % 8] ^ c[i];
        end
        return r;
    endfunction

    // Inverse S-box: inverse affine transform (constant 0x05), then inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] d;
        d = 8'h05;
        for (int i = 0; i < 8; i++) begin
            t[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ d[i];
        end
        return gf_inv(t);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One key-schedule step: RotWord, SubWord, Rcon, then word chaining.
    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        logic [31:0] t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Row r is rotated right by r columns: out[r][c] = in[r][(c - r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127 - 8*k -: 8] = inv_sbox(s[127 - 8*k -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c      -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                    ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[127 - 32*c - 8  -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                    ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[127 - 32*c - 16 -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                    ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[127 - 32*c - 24 -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                    ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // A busy state keeps working only while START stays high; otherwise it aborts.
    assign run_ok   = AES_START;
    assign AES_DONE = (state_q == DONE);
    assign AES_BUSY = (state_q != IDLE) && (state_q != DONE);

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic, including abort on START low in any busy state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (AES_START) state_d = KEYEXP;
            KEYEXP:    if (!run_ok) state_d = IDLE;
                       else if (round_cnt == 4'd10) state_d = INIT;
            INIT:      state_d = run_ok ? INV_SHIFT : IDLE;
            INV_SHIFT: state_d = run_ok ? INV_SUB : IDLE;
            INV_SUB:   state_d = run_ok ? ADD_KEY : IDLE;
            ADD_KEY:   if (!run_ok) state_d = IDLE;
                       else if (round_cnt == 4'd0) state_d = DONE;
                       else state_d = INV_MIX;
            INV_MIX:   state_d = run_ok ? INV_SHIFT : IDLE;
            DONE:      if (!AES_START) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Datapath: input latch, key schedule, round sub-steps and result register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            aes_state   <= '0;
            round_cnt   <= 4'd0;
            AES_MSG_DEC <= '0;
            for (int i = 0; i <= 10; i++) rk[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (AES_START) begin
                        rk[0]     <= AES_KEY;
                        aes_state <= AES_MSG_ENC;
                        round_cnt <= 4'd1;
                    end
                end
                KEYEXP: begin
                    if (run_ok) begin
                        rk[round_cnt] <= key_next(rk[round_cnt - 4'd1], rcon(round_cnt));
                        if (round_cnt != 4'd10) round_cnt <= round_cnt + 4'd1;
                    end
                end
                INIT: begin
                    if (run_ok) begin
                        aes_state <= aes_state ^ rk[10];
                        round_cnt <= 4'd9;
                    end
                end
                INV_SHIFT: begin
                    if (run_ok) aes_state <= inv_shift_rows(aes_state);
                end
                INV_SUB: begin
                    if (run_ok) aes_state <= inv_sub_bytes(aes_state);
                end
                ADD_KEY: begin
                    if (run_ok) begin
                        aes_state <= aes_state ^ rk[round_cnt];
                        if (round_cnt == 4'd0) AES_MSG_DEC <= aes_state ^ rk[0];
                    end
                end
                INV_MIX: begin
                    if (run_ok) begin
                        aes_state <= inv_mix_columns(aes_state);
                        round_cnt <= round_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
